// File: rtl/vip_frame_sequencer.sv
// vip_frame_sequencer: sequences one video frame between a VIP decoder and encoder.
// It captures a control packet, requests an encoder control packet, waits for the
// encoder to settle, streams pixels with zero latency while tracking the column and
// line, then drains any overlong frame and signals end-of-frame to the encoder.
// Optional feature macro: VIP_SEQ_FRAME_CHECK_EN enables the sticky
// frame_short/frame_long flags. When it is undefined, both flags are tied to 0.
module vip_frame_sequencer #(
  parameter int unsigned PIX_BITS      = 16,
  parameter int unsigned MIN_CTRL_WAIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                stall_out,
  input  logic [15:0]         width_in,
  input  logic [15:0]         height_in,
  input  logic [3:0]          interlaced_in,
  input  logic                vip_ctrl_valid,
  input  logic                end_of_video,
  input  logic                vip_ctrl_busy,
  output logic                read,
  output logic                write,
  output logic [15:0]         width_out,
  output logic [15:0]         height_out,
  output logic [3:0]          interlaced_out,
  output logic                vip_ctrl_send,
  output logic                end_of_video_out,
  output logic [PIX_BITS-1:0] pix_x,
  output logic [PIX_BITS-1:0] pix_y,
  output logic                frame_active,
  output logic                frame_short,
  output logic                frame_long
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CTRL,
    S_WAIT_CTRL,
    S_STREAM,
    S_DRAIN,
    S_EOF
  } state_t;

  // The wait counter stops at WAIT_LAST. The exit test is made in that cycle,
  // so at least MIN_CTRL_WAIT cycles are spent in WAIT_CTRL.
  localparam int unsigned WAIT_W = $clog2(MIN_CTRL_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MIN_CTRL_WAIT > 0) ? (MIN_CTRL_WAIT - 1) : 0);

  state_t              state_q, state_d;
  logic [PIX_BITS-1:0] pix_x_q, pix_x_d;
  logic [PIX_BITS-1:0] pix_y_q, pix_y_d;
  logic [15:0]         width_q, width_d;
  logic [15:0]         height_q, height_d;
  logic [3:0]          interlaced_q, interlaced_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
`ifdef VIP_SEQ_FRAME_CHECK_EN
  logic                short_q, short_d;
  logic                long_q, long_d;
`endif

  logic                read_c, write_c, send_c, eov_c;
  logic                xfer;
  logic [PIX_BITS-1:0] x_end, y_end;
  logic                x_last, at_last;

  // Next-state, counter and registered-field updates, and the combinational handshakes.
  always_comb begin
    state_d      = state_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    width_d      = width_q;
    height_d     = height_q;
    interlaced_d = interlaced_q;
    wait_d       = wait_q;
`ifdef VIP_SEQ_FRAME_CHECK_EN
    short_d      = short_q;
    long_d       = long_q;
`endif
    read_c       = 1'b0;
    write_c      = 1'b0;
    send_c       = 1'b0;
    eov_c        = 1'b0;

    xfer    = ~stall_in & ~stall_out;
    x_end   = PIX_BITS'(width_q - 16'd1);
    y_end   = PIX_BITS'(height_q - 16'd1);
    x_last  = (pix_x_q == x_end);
    at_last = x_last & (pix_y_q == y_end);

    unique case (state_q)
      S_IDLE: begin
        read_c = 1'b1;
        if (vip_ctrl_valid && (width_in != '0) && (height_in != '0)) begin
          width_d      = width_in;
          height_d     = height_in;
          interlaced_d = interlaced_in;
          state_d      = S_SEND_CTRL;
`ifdef VIP_SEQ_FRAME_CHECK_EN
          short_d      = 1'b0;
          long_d       = 1'b0;
`endif
        end
      end
      S_SEND_CTRL: begin
        if (!vip_ctrl_busy) begin
          send_c  = 1'b1;
          wait_d  = '0;
          state_d = S_WAIT_CTRL;
        end
      end
      S_WAIT_CTRL: begin
        if (wait_q != WAIT_LAST) begin
          wait_d = wait_q + 1'b1;
        end else if (!vip_ctrl_busy) begin
          pix_x_d = '0;
          pix_y_d = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        read_c  = xfer;
        write_c = xfer;
        if (xfer) begin
          if (x_last) begin
            pix_x_d = '0;
            pix_y_d = pix_y_q + 1'b1;
          end else begin
            pix_x_d = pix_x_q + 1'b1;
          end
          if (end_of_video) begin
            state_d = S_EOF;
`ifdef VIP_SEQ_FRAME_CHECK_EN
            if (!at_last) short_d = 1'b1;
`endif
          end else if (at_last) begin
            state_d = S_DRAIN;
`ifdef VIP_SEQ_FRAME_CHECK_EN
            long_d  = 1'b1;
`endif
          end
        end
      end
      S_DRAIN: begin
        read_c = ~stall_in;
        if (!stall_in && end_of_video) state_d = S_EOF;
      end
      S_EOF: begin
        eov_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      width_q      <= '0;
      height_q     <= '0;
      interlaced_q <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      width_q      <= width_d;
      height_q     <= height_d;
      interlaced_q <= interlaced_d;
      wait_q       <= wait_d;
    end
  end

`ifdef VIP_SEQ_FRAME_CHECK_EN
  // Sticky frame-length flags, cleared on reset and when the next frame is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      short_q <= short_d;
      long_q  <= long_d;
    end
  end
  assign frame_short = short_q;
  assign frame_long  = long_q;
`else
  assign frame_short = 1'b0;
  assign frame_long  = 1'b0;
`endif

  // The handshakes are gated by rst. This keeps a frame that is abandoned
  // mid-stream from emitting a beat or end marker during reset.
  assign read             = read_c  & ~rst;
  assign write            = write_c & ~rst;
  assign vip_ctrl_send    = send_c  & ~rst;
  assign end_of_video_out = eov_c   & ~rst;
  assign width_out        = width_q;
  assign height_out       = height_q;
  assign interlaced_out   = interlaced_q;
  assign pix_x            = pix_x_q;
  assign pix_y            = pix_y_q;
  assign frame_active     = (state_q == S_STREAM) || (state_q == S_DRAIN);

endmodule
